// File: rtl/complex_pkg.sv
// Shared widths, FSM states and saturation bounds for the complex divider.
package complex_pkg;
    localparam int Z_W   = 16;
    localparam int B_W   = 8;
    localparam int A_W   = 8;
    localparam int NUM_W = Z_W + B_W + 1;
    localparam int DEN_W = 2 * B_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SAT_MAX = (1 << (A_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (A_W - 1));
endpackage

// File: rtl/complex_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, subtract the divisor when it fits, shift the quotient bit in.
module complex_div_step #(
    parameter int NUM_W = 25,
    parameter int DEN_W = 16
) (
    input  logic [DEN_W-1:0] rem_i,
    input  logic [NUM_W-1:0] quo_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [DEN_W-1:0] rem_o,
    output logic [NUM_W-1:0] quo_o
);
    logic [DEN_W:0] shifted;
    logic           fits;

    // quo_i holds the unconsumed dividend bits at the top and the quotient
    // bits built so far at the bottom.
    always_comb begin
        shifted = {rem_i, quo_i[NUM_W-1]};
        fits    = (shifted >= {1'b0, den_i});
        rem_o   = fits ? (shifted[DEN_W-1:0] - den_i) : shifted[DEN_W-1:0];
        quo_o   = {quo_i[NUM_W-2:0], fits};
    end
endmodule

// File: rtl/complex_div.sv
// Iterative complex divider a = z / b, computing z*conj(b) / |b|^2 with a
// restoring divider per lane; real and imaginary lanes run in lockstep.
module complex_div #(
    parameter int Z_W = complex_pkg::Z_W,
    parameter int B_W = complex_pkg::B_W,
    parameter int A_W = complex_pkg::A_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [Z_W-1:0] z_real,
    input  logic signed [Z_W-1:0] z_imag,
    input  logic signed [B_W-1:0] b_real,
    input  logic signed [B_W-1:0] b_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [A_W-1:0] a_real,
    output logic signed [A_W-1:0] a_imag,
    output logic                  overflow,
    output logic                  div_by_zero
);
    import complex_pkg::*;

    localparam int NUM_W = Z_W + B_W + 1;
    localparam int DEN_W = 2 * B_W;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [NUM_W-1:0] NEG_LIM = NUM_W'(1) << (A_W - 1);
    localparam logic [NUM_W-1:0] POS_LIM = NEG_LIM - NUM_W'(1);
    localparam logic [A_W-1:0]   MAX_VAL = {1'b0, {(A_W-1){1'b1}}};
    localparam logic [A_W-1:0]   MIN_VAL = {1'b1, {(A_W-1){1'b0}}};

    state_e                  state_q, state_d;
    logic signed [Z_W-1:0]   zr_q, zr_d, zi_q, zi_d;
    logic signed [B_W-1:0]   br_q, br_d, bi_q, bi_d;
    logic [DEN_W-1:0]        den_q, den_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0][DEN_W-1:0]   rem_q, rem_d, rem_s;
    logic [1:0][NUM_W-1:0]   quo_q, quo_d, quo_s;
    logic [1:0]              neg_q, neg_d;
    logic [1:0][A_W-1:0]     a_q, a_d;
    logic                    ovf_q, ovf_d, dbz_q, dbz_d;

    logic signed [NUM_W-1:0] zr_x, zi_x, br_x, bi_x;
    logic signed [DEN_W-1:0] br_y, bi_y;
    logic signed [NUM_W-1:0] num [2];
    logic [DEN_W-1:0]        den_calc;
    logic [1:0][A_W:0]       sat;

    // Returns {overflow, clamped signed quotient} from a magnitude and sign.
    function automatic logic [A_W:0] saturate(input logic [NUM_W-1:0] mag, input logic neg);
        logic [A_W-1:0] lo;
        lo = mag[A_W-1:0];
        if (neg) begin
            if (mag > NEG_LIM) return {1'b1, MIN_VAL};
            return {1'b0, -lo};
        end
        if (mag > POS_LIM) return {1'b1, MAX_VAL};
        return {1'b0, lo};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        complex_div_step #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_step (
            .rem_i (rem_q[gi]),
            .quo_i (quo_q[gi]),
            .den_i (den_q),
            .rem_o (rem_s[gi]),
            .quo_o (quo_s[gi])
        );
    end

    always_comb begin
        zr_x     = NUM_W'(zr_q);
        zi_x     = NUM_W'(zi_q);
        br_x     = NUM_W'(br_q);
        bi_x     = NUM_W'(bi_q);
        br_y     = DEN_W'(br_q);
        bi_y     = DEN_W'(bi_q);
        num[0]   = zr_x * br_x + zi_x * bi_x;
        num[1]   = zi_x * br_x - zr_x * bi_x;
        den_calc = br_y * br_y + bi_y * bi_y;
        for (int i = 0; i < 2; i++) sat[i] = saturate(quo_s[i], neg_q[i]);

        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        br_d    = br_q;
        bi_d    = bi_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        neg_d   = neg_q;
        a_d     = a_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: if (in_valid) begin
                zr_d    = z_real;
                zi_d    = z_imag;
                br_d    = b_real;
                bi_d    = b_imag;
                state_d = PREP;
            end
            PREP: begin
                den_d = den_calc;
                if (den_calc == '0) begin
                    a_d     = '0;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        neg_d[i] = num[i][NUM_W-1];
                        quo_d[i] = num[i][NUM_W-1] ? NUM_W'(-num[i]) : NUM_W'(num[i]);
                    end
                    rem_d   = '0;
                    cnt_d   = CNT_W'(NUM_W);
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = rem_s;
                quo_d = quo_s;
                cnt_d = cnt_q - CNT_W'(1);
                // The last step's quotient is signed and clamped on the way out.
                if (cnt_q == CNT_W'(1)) begin
                    a_d[0]  = sat[0][A_W-1:0];
                    a_d[1]  = sat[1][A_W-1:0];
                    ovf_d   = sat[0][A_W] | sat[1][A_W];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            zr_q    <= '0;
            zi_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            neg_q   <= '0;
            a_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign a_real      = a_q[0];
    assign a_imag      = a_q[1];
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_complex_div.sv
// Scoreboard bench for complex_div: random and directed operands checked
// against an integer-arithmetic reference model.
module tb_complex_div;
    localparam int Z_W = 16;
    localparam int B_W = 8;
    localparam int A_W = 8;
    localparam int NUM_W = Z_W + B_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, overflow, div_by_zero;
    logic signed [Z_W-1:0] z_real = '0, z_imag = '0;
    logic signed [B_W-1:0] b_real = '0, b_imag = '0;
    logic signed [A_W-1:0] a_real, a_imag;

    typedef struct {
        int ar; int ai; bit ovf; bit dbz; int lat; int acc; int hold;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   cyc = 0;
    int   outs_seen = 0;
    bit   inflight = 1'b0;
    bit   chk_en = 1'b0;

    complex_div dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .z_real(z_real), .z_imag(z_imag), .b_real(b_real), .b_imag(b_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_real(a_real), .a_imag(a_imag),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // An operation is in flight from its accept until its result handshake.
    always @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else if (in_valid && in_ready) inflight <= 1'b1;
        else if (out_valid && out_ready) inflight <= 1'b0;
    end

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic int rs(input int bits);
        int v;
        v = int'($urandom_range((1 << bits) - 1, 0));
        return v - (1 << (bits - 1));
    endfunction

    function automatic int clamp(input int q, output bit ovf);
        ovf = 1'b0;
        if (q > 127)  begin ovf = 1'b1; return 127;  end
        if (q < -128) begin ovf = 1'b1; return -128; end
        return q;
    endfunction

    function automatic exp_t model(input int zr, input int zi, input int br, input int bi);
        exp_t e;
        int nr, ni, d;
        bit o1, o2;
        nr = zr * br + zi * bi;
        ni = zi * br - zr * bi;
        d  = br * br + bi * bi;
        e.acc = 0;
        e.hold = 0;
        if (d == 0) begin
            e.ar = 0; e.ai = 0; e.ovf = 1'b0; e.dbz = 1'b1; e.lat = 2;
        end else begin
            e.ar  = clamp(nr / d, o1);
            e.ai  = clamp(ni / d, o2);
            e.ovf = o1 | o2;
            e.dbz = 1'b0;
            e.lat = NUM_W + 2;
        end
        return e;
    endfunction

    task automatic send(input int zr, input int zi, input int br, input int bi,
                        input int hold, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        z_real = Z_W'(zr);
        z_imag = Z_W'(zi);
        b_real = B_W'(br);
        b_imag = B_W'(bi);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e = model(zr, zi, br, bi);
            e.acc = cyc;
            e.hold = hold;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per presented result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                outs_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn: a_real=%0d a_imag=%0d overflow=%0b div_by_zero=%0b (expected %0d %0d %0b %0b)",
                             a_real, a_imag, overflow, div_by_zero, e.ar, e.ai, e.ovf, e.dbz);
                    check("latency", cyc - e.acc + 1, e.lat);
                    check("a_real", a_real, e.ar);
                    check("a_imag", a_imag, e.ai);
                    check("overflow", overflow, e.ovf);
                    check("div_by_zero", div_by_zero, e.dbz);
                    for (int k = 0; k < e.hold; k++) begin
                        @(negedge clk);
                        check("hold_valid", out_valid, 1);
                        check("hold_a_real", a_real, e.ar);
                        check("hold_a_imag", a_imag, e.ai);
                        check("hold_overflow", overflow, e.ovf);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("in_ready", in_ready, inflight ? 0 : 1);
    end

    initial begin
        int n, o, zr, zi, br, bi, ar, ai;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_a_real", a_real, 0);
        check("rst_a_imag", a_imag, 0);
        check("rst_overflow", overflow, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        send(0, 1875, 15, 30, 0, 1);
        send(-5, 10, 3, 4, 0, 1);
        // Operands offered mid-division must be ignored.
        repeat (5) @(negedge clk);
        z_real = 16'sd999; z_imag = 16'sd999; b_real = 8'sd1; b_imag = 8'sd0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        send(-7, 0, 2, 0, 0, 1);
        send(1000, 0, 1, 0, 0, 1);
        send(-1000, 0, 1, 0, 0, 1);
        send(5, 5, 0, 0, 0, 1);
        send(300, -200, 7, -9, 10, 1);

        // Abort an operation with reset during DIV step 10.
        send(0, 1875, 15, 30, 0, 0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("in_ready_after_rst", in_ready, 1);
        o = outs_seen;
        repeat (40) @(negedge clk);
        check("no_output_after_abort", outs_seen, o);
        send(-5, 10, 3, 4, 0, 1);

        for (int t = 0; t < 40; t++) begin
            br = rs(8);
            bi = rs(8);
            if ($urandom_range(9, 0) == 0) begin
                br = 0;
                bi = 0;
            end
            if ($urandom_range(2, 0) == 0) begin
                ar = rs(7); ai = rs(7); br = rs(7); bi = rs(7);
                zr = ar * br - ai * bi;
                zi = ar * bi + ai * br;
            end else begin
                zr = rs(16);
                zi = rs(16);
            end
            send(zr, zi, br, bi, int'($urandom_range(2, 0)), 1);
        end

        n = 0;
        while ((exp_q.size() != 0 || inflight) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
